// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream into RAM port-B words for one framed buffer fill
module byte_word_packer #(
   parameter int WIDTHA     = 8,
   parameter int WIDTHB     = 32,
   parameter int SIZEB      = 64,
   parameter int ADDRWIDTHB = 6
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   input  logic                                          s_valid,
   output logic                                          s_ready,
   input  logic [WIDTHA-1:0]                             s_data,
   input  logic                                          s_last,
   output logic                                          weB,
   output logic [ADDRWIDTHB-1:0]                         addrB,
   output logic [WIDTHB-1:0]                             diB,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          overflow,
   output logic [ADDRWIDTHB+$clog2(WIDTHB/WIDTHA):0]     byte_count
);

   localparam int RATIO = WIDTHB / WIDTHA;
   localparam int LR    = $clog2(RATIO);
   localparam int CW    = ADDRWIDTHB + LR + 1;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t                state, state_next;
   logic [LR-1:0]         lane;
   logic [ADDRWIDTHB:0]   word_ptr;
   logic [WIDTHB-1:0]     asm_word;
   logic [WIDTHB-1:0]     merged;
   logic                  accept, word_end, buf_full, restart;

   always_comb begin
      accept   = s_valid & s_ready;
      word_end = accept & ((lane == LR'(RATIO - 1)) | s_last);
      buf_full = (lane == LR'(RATIO - 1)) && (word_ptr == (ADDRWIDTHB + 1)'(SIZEB - 1));
      // lanes above the current one are always zero because asm_word clears after each write
      merged   = asm_word;
      for (int i = 0; i < RATIO; i++) begin
         if (lane == LR'(i)) merged[i*WIDTHA +: WIDTHA] = s_data;
      end
   end

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = FILL;
               restart    = 1'b1;
            end
         end
         FILL: begin
            if (word_end && (s_last || buf_full)) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               state_next = FILL;
               restart    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         s_ready    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         weB        <= 1'b0;
         addrB      <= '0;
         diB        <= '0;
         byte_count <= '0;
         lane       <= '0;
         word_ptr   <= '0;
         asm_word   <= '0;
      end else begin
         state   <= state_next;
         s_ready <= (state_next == FILL);
         busy    <= (state_next == FILL);
         done    <= (state_next == DONE);
         weB     <= 1'b0;
         if (restart) begin
            lane       <= '0;
            word_ptr   <= '0;
            asm_word   <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
         end else if (accept) begin
            byte_count <= byte_count + CW'(1);
            if (word_end) begin
               weB      <= 1'b1;
               addrB    <= word_ptr[ADDRWIDTHB-1:0];
               diB      <= merged;
               word_ptr <= word_ptr + (ADDRWIDTHB + 1)'(1);
               lane     <= '0;
               asm_word <= '0;
               if (buf_full && !s_last) overflow <= 1'b1;
            end else begin
               asm_word <= merged;
               lane     <= lane + LR'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - scoreboard bench for byte_word_packer
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = '0;
   logic        s_last = 1'b0;
   logic        weB;
   logic [5:0]  addrB;
   logic [31:0] diB;
   logic        busy, done, overflow;
   logic [8:0]  byte_count;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [5:0]  last_addr;
   logic [31:0] last_data;
   logic [37:0] exp_q[$];

   int          m_lane;
   logic [5:0]  m_ptr;
   logic [31:0] m_word;

   byte_word_packer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .weB(weB), .addrB(addrB), .diB(diB),
      .busy(busy), .done(done), .overflow(overflow), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && weB) begin
         logic [37:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h", addrB, diB);
         end else begin
            e = exp_q.pop_front();
            if ({addrB, diB} !== e) begin
               errors++;
               $display("FAIL write_scoreboard got addr=%0d data=%h expected addr=%0d data=%h",
                        addrB, diB, e[37:32], e[31:0]);
            end
         end
         wr_count++;
         last_addr = addrB;
         last_data = diB;
      end
   end

   task automatic model_clear();
      m_lane = 0;
      m_ptr  = '0;
      m_word = '0;
   endtask

   task automatic model_accept(input logic [7:0] d, input logic last);
      m_word = m_word | ({24'h0, d} << (m_lane * 8));
      if (m_lane == 3 || last) begin
         exp_q.push_back({m_ptr, m_word});
         m_ptr  = m_ptr + 6'd1;
         m_lane = 0;
         m_word = '0;
      end else begin
         m_lane++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input bit restarts);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      if (restarts) model_clear();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      int n;
      s_valid = 1'b0;
      tick(gap);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      n = 0;
      while (!s_ready && n < 20) begin
         tick(1);
         n++;
      end
      checks++;
      if (!s_ready) begin
         errors++;
         $display("FAIL send_timeout s_ready=%b required 1", s_ready);
      end else begin
         model_accept(d, last);
         tick(1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s pending_writes=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      model_clear();
   endtask

   task automatic test_reset();
      tick(3);
      checks++;
      if ({s_ready, weB, addrB, diB, busy, done, overflow, byte_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0",
                  {s_ready, weB, addrB, diB, busy, done, overflow, byte_count});
      end
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset s_ready=%b busy=%b required 0 0", s_ready, busy);
      end
   endtask

   task automatic test_single_word();
      int w0 = wr_count;
      pulse_start(1);
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      send_byte(8'h33, 0, 0);
      send_byte(8'h44, 0, 0);
      tick(2);
      check_drained("single_word");
      checks++;
      if (wr_count - w0 != 1 || last_addr !== 6'd0 || last_data !== 32'h44332211) begin
         errors++;
         $display("FAIL single_word writes=%0d addr=%0d data=%h required 1 0 44332211",
                  wr_count - w0, last_addr, last_data);
      end
      checks++;
      if (byte_count !== 9'd4 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL single_word_state count=%0d busy=%b done=%b required 4 1 0",
                  byte_count, busy, done);
      end
   endtask

   task automatic test_last_frame();
      pulse_start(1);
      for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11), i == 6, 0);
      checks++;
      if (done !== 1'b1 || overflow !== 1'b0 || byte_count !== 9'd6 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL last_frame done=%b ovf=%b count=%0d ready=%b required 1 0 6 0",
                  done, overflow, byte_count, s_ready);
      end
      tick(2);
      check_drained("last_frame");
      checks++;
      if (last_addr !== 6'd1 || last_data !== 32'h00006655) begin
         errors++;
         $display("FAIL last_frame_partial addr=%0d data=%h required 1 00006655",
                  last_addr, last_data);
      end
   endtask

   task automatic test_overflow();
      int w0 = wr_count;
      int accepted = 0;
      int ready_after = 0;
      pulse_start(1);
      for (int i = 0; i < 300; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         s_last  = 1'b0;
         if (s_ready) begin
            accepted++;
            if (accepted > 256) ready_after++;
            model_accept(8'(i), 1'b0);
         end
         tick(1);
      end
      s_valid = 1'b0;
      tick(2);
      check_drained("overflow");
      checks++;
      if (accepted != 256 || ready_after != 0 || wr_count - w0 != 64) begin
         errors++;
         $display("FAIL overflow_counts accepted=%0d writes=%0d required 256 64",
                  accepted, wr_count - w0);
      end
      checks++;
      if (overflow !== 1'b1 || done !== 1'b1 || byte_count !== 9'd256 || last_addr !== 6'd63) begin
         errors++;
         $display("FAIL overflow_state ovf=%b done=%b count=%0d addr=%0d required 1 1 256 63",
                  overflow, done, byte_count, last_addr);
      end
   endtask

   task automatic test_gaps();
      int w0 = wr_count;
      pulse_start(1);
      for (int i = 0; i < 9; i++) send_byte(8'(8'hAA + i), i == 8, int'($urandom_range(0, 3)));
      tick(2);
      check_drained("gaps");
      checks++;
      if (wr_count - w0 != 3 || last_addr !== 6'd2 || last_data !== 32'h000000B2) begin
         errors++;
         $display("FAIL gaps writes=%0d addr=%0d data=%h required 3 2 000000b2",
                  wr_count - w0, last_addr, last_data);
      end
      checks++;
      if (done !== 1'b1 || overflow !== 1'b0 || byte_count !== 9'd9) begin
         errors++;
         $display("FAIL gaps_state done=%b ovf=%b count=%0d required 1 0 9", done, overflow, byte_count);
      end
   endtask

   task automatic test_start_in_fill();
      pulse_start(1);
      send_byte(8'h01, 0, 0);
      send_byte(8'h02, 0, 0);
      pulse_start(0);
      send_byte(8'h03, 0, 0);
      send_byte(8'h04, 0, 1);
      tick(2);
      check_drained("start_in_fill");
      checks++;
      if (last_addr !== 6'd0 || last_data !== 32'h04030201 || byte_count !== 9'd4) begin
         errors++;
         $display("FAIL start_in_fill addr=%0d data=%h count=%0d required 0 04030201 4",
                  last_addr, last_data, byte_count);
      end
      send_byte(8'h05, 1, 0);
      tick(2);
      check_drained("start_in_fill_end");
      pulse_start(1);
      checks++;
      if (byte_count !== 9'd0 || done !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_from_done count=%0d done=%b busy=%b ready=%b required 0 0 1 1",
                  byte_count, done, busy, s_ready);
      end
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 0, 0);
      tick(2);
      check_drained("restart_from_done");
      checks++;
      if (last_addr !== 6'd0 || last_data !== 32'hC3C2C1C0) begin
         errors++;
         $display("FAIL restart_addr addr=%0d data=%h required 0 c3c2c1c0", last_addr, last_data);
      end
   endtask

   task automatic test_reset_mid_fill();
      int w0;
      pulse_start(1);
      send_byte(8'h71, 0, 0);
      send_byte(8'h72, 0, 0);
      send_byte(8'h73, 0, 0);
      w0 = wr_count;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_ready, weB, addrB, diB, busy, done, overflow, byte_count} !== '0) begin
         errors++;
         $display("FAIL reset_mid_fill got %h required 0",
                  {s_ready, weB, addrB, diB, busy, done, overflow, byte_count});
      end
      tick(2);
      rst_n = 1'b1;
      model_clear();
      tick(3);
      checks++;
      if (wr_count != w0 || busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_write writes=%0d busy=%b required %0d 0", wr_count, busy, w0);
      end
      pulse_start(1);
      for (int i = 0; i < 4; i++) send_byte(8'(8'h81 + i), 0, 0);
      tick(2);
      check_drained("reset_recover");
      checks++;
      if (wr_count - w0 != 1 || last_addr !== 6'd0 || last_data !== 32'h84838281) begin
         errors++;
         $display("FAIL reset_recover writes=%0d addr=%0d data=%h required 1 0 84838281",
                  wr_count - w0, last_addr, last_data);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single_word();
      apply_reset();
      test_last_frame();
      test_overflow();
      test_gaps();
      test_start_in_fill();
      test_reset_mid_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
